// File: rtl/rv_pkg.sv
// Shared RISC-V core constants.
// Widths, reset PC, NOP encoding and PC increment.
package rv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush.
// Output is always taken from storage, never bypassed.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = empty ? last : mem[head];

    // Storage write at tail; cleared on reset so outputs start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && push_ok) begin
            mem[tail] <= wdata;
        end
    end

    // Pointers, occupancy and last-popped word; flush empties everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            last  <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PW'(1);
            end
            if (pop_ok) begin
                head <= head + PW'(1);
                last <= mem[head];
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC register, instr_mem request and fetch queue to decode.
// Redirects from EX flush the queue and reload the PC.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC,
    parameter int          QDEPTH   = 2,
    parameter int          XLEN     = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr,
    input  logic            dec_ready
);

    logic [XLEN-1:0]   pc;
    logic [2*XLEN-1:0] rdata;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign imem_pc   = pc;
    assign dec_valid = ~empty;
    assign pop       = dec_valid & dec_ready;
    assign push      = fetch_en & ~redirect_valid & (~full | pop);
    assign dec_pc    = rdata[2*XLEN-1:XLEN];
    assign dec_instr = rdata[XLEN-1:0];

    // PC: redirect wins, otherwise advance by one word on each push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= XLEN'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + XLEN'(PC_STEP);
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2*XLEN)
    ) u_fetch_queue (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({pc, imem_instr}),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Random and directed stimulus for instr_fetch_unit.
// Checked against a queue-based model of the fetch rules.
module tb_instr_fetch_unit;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic [31:0] imem_pc, imem_instr;
    logic        dec_valid;
    logic [31:0] dec_pc, dec_instr;

    logic [31:0] w_imem_pc, w_imem_instr;
    logic        w_dec_valid;
    logic [31:0] w_dec_pc, w_dec_instr;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq [$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    assign imem_instr   = imem_pc ^ 32'hA5A5_0000;
    assign w_imem_instr = w_imem_pc ^ 32'hA5A5_0000;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QD),
        .XLEN     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_ready      (dec_ready)
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .QDEPTH   (QD),
        .XLEN     (32)
    ) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (1'b1),
        .imem_pc        (w_imem_pc),
        .imem_instr     (w_imem_instr),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .dec_valid      (w_dec_valid),
        .dec_pc         (w_dec_pc),
        .dec_instr      (w_dec_instr),
        .dec_ready      (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: check, drive, advance model over one posedge.
    task automatic step(input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        bit full;
        bit pop;
        chk("imem_pc", imem_pc, mpc);
        chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("dec_pc", dec_pc, mq[0][63:32]);
            chk("dec_instr", dec_instr, mq[0][31:0]);
        end
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        @(posedge clk);
        full = (mq.size() == QD);
        pop  = (mq.size() != 0) && rdy;
        if (rv) begin
            mq.delete();
            mpc = rpc & ~32'd3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (fe && (!full || pop)) begin
                mq.push_back({mpc, mpc ^ 32'hA5A5_0000});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(posedge rst);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wrap_valid", 32'(w_dec_valid), 32'd1);
            chk("wrap_pc", w_dec_pc, 32'hFFFF_FFF8 + 32'(4 * k));
            chk("wrap_instr", w_dec_instr,
                (32'hFFFF_FFF8 + 32'(4 * k)) ^ 32'hA5A5_0000);
        end
    end

    initial begin
        rst            = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        mpc            = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_imem_pc", imem_pc, 32'h0);
        rst = 1'b1;

        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h103, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_first", dec_pc, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_second", dec_pc, 32'h104);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);

        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);

        repeat (4) step(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));

        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(dec_valid), 32'd0);
        chk("midrst_imem_pc", imem_pc, 32'h0);
        chk("midrst_dec_pc", dec_pc, 32'h0);
        mq.delete();
        mpc = 32'h0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 11) == 0),
                 $urandom,
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
